din_wled_rx: RTL and testbench
==============================

// Module: din_wled_rx
// PURPOSE
//  Receiver for the single-wire WS2812 NRZ LED protocol. Decodes a GRB pixel stream into 24-bit words and one-bit-per-colour vectors.
//  Sits in the input-plugin path: captures an external WS2812 chain or loops back the dout_wled output for self-test.
// PARAMETERS
//  CLK_MHZ     27    system clock frequency in MHz; all timing thresholds derive from it
//  NUM_LEDS    1     number of pixels stored per frame (1..255)
//  THRESH_NS   625   high time at or above this decodes as '1'; below it decodes as '0'
//  MIN_HIGH_NS 150   high pulses shorter than this are glitches (error)
//  MAX_HIGH_NS 1000  high pulses longer than this are errors
//  RESET_US    50    low time that ends a frame (latch)
// PORTS
//  clk         in   1         system clock
//  rst_n       in   1         asynchronous active-low reset
//  wled_in     in   1         asynchronous serial input
//  rgb_data    out  24        last decoded word {G[23:16],R[15:8],B[7:0]}, MSB first on wire
//  led_num     out  8         pixel index of rgb_data within the current frame
//  word_valid  out  1         1-cycle strobe; rgb_data and led_num are valid
//  frame_done  out  1         1-cycle strobe; green, red and blue have just updated
//  green       out  NUM_LEDS  per-pixel G byte >= 128, latched per frame
//  red         out  NUM_LEDS  per-pixel R byte >= 128, latched per frame
//  blue        out  NUM_LEDS  per-pixel B byte >= 128, latched per frame
//  err         out  1         1-cycle strobe on a glitch, long-high or partial-word event
// BEHAVIOUR
//  - Reset: all outputs 0; FSM=SYNC; counters 0; shadow vectors 0.
//  - wled_in passes through a 2-flop synchronizer, then an edge detector.
//  - Cycle constants: C_x = (CLK_MHZ*x_NS)/1000, integer truncation.
//    At 27 MHz: THRESH=16, MIN=4, MAX=27, RESET=CLK_MHZ*RESET_US=1350.
//  - tcnt is a 16-bit saturating counter. It clears on every synced edge and increments otherwise.
//  - SYNC: ignore data until the line has been low for C_RESET; then go to LOW. Gives clean lock after power-up or error.
//  - LOW, rising edge: go to HIGH.
//  - LOW, low count reaches C_RESET:
//    - if bit_cnt != 0: raise err and discard the partial word;
//    - in the same cycle, copy the shadow vectors to green/red/blue, pulse frame_done, clear pix_cnt, stay in LOW.
//    - frame_done fires once per gap, not repeatedly.
//  - HIGH, tcnt exceeds C_MAX: raise err, go to SYNC, clear bit_cnt and pix_cnt.
//  - HIGH, falling edge with tcnt < C_MIN: raise err, go to SYNC, clear bit_cnt and pix_cnt.
//  - HIGH, falling edge otherwise: shift in bit = (tcnt >= C_THRESH), bit_cnt++, go to LOW.
//  - On the 24th bit, next cycle:
//    - rgb_data <= word; led_num <= pix_cnt; word_valid = 1;
//    - if pix_cnt < NUM_LEDS, write shadow[pix_cnt] = {G[7],R[7],B[7]};
//    - pix_cnt increments, saturating at 255; words beyond NUM_LEDS are strobed but not stored.
//  - Latency: word_valid asserts 4 clk edges after wled_in falls at the end of bit 23 (2 sync, 1 edge/classify, 1 output register).
//  - Simultaneous events: the err strobe and frame_done may assert in the same cycle.
//  - rst_n low mid-frame returns the block to SYNC at once and clears all outputs.
// STRUCTURE
//  - Shared header ws2812_defs.vh holds:
//    - nominal timing constants T0H=400, T1H=800, TBIT=1250 ns, RESET=50 us;
//    - the ns/us-to-cycles macros;
//    - the 2-bit state encodings SYNC/LOW/HIGH.
//  - The transmitter uses the same header.
//  - One sub-module, wled_sync_edge: 2-flop synchronizer with rise/fall strobe outputs.
//  - Everything else lives in this file.
// TESTING (CLK_MHZ=27, NUM_LEDS=2; bench TX: T0H=11, T1H=22, period=34 cycles)
//  - Lock: reset, hold line low 1400 cycles, send 0xFF0000, 0x0000FF, low 1400.
//    -> word_valid x2 with led_num 0 then 1.
//    -> frame_done once; green=2'b01, red=2'b00, blue=2'b10.
//  - No lock: send a word without the initial 1350-cycle low.
//    -> no word_valid; decoding starts after the first full reset gap.
//  - Glitch: a 3-cycle high pulse mid-word.
//    -> err for 1 cycle; no word_valid until a gap plus a fresh word, which then decodes correctly.
//  - Partial word: 12 bits, then low 1400.
//    -> err and frame_done in the same cycle; vectors are unchanged except that frames of 0 complete words latch the prior shadow.
//  - Overflow: 3 words into NUM_LEDS=2.
//    -> 3 word_valid strobes with led_num 0,1,2; only pixels 0 and 1 land in the vectors.
//  - Async reset: assert rst_n low at bit 10 of word 1.
//    -> all outputs 0 immediately; after release, the next frame decodes only after a reset gap.

Source files
------------

// File: rtl/din_wled_rx_pkg.sv
// Shared definitions for the WS2812 receiver: FSM encoding and ns/us-to-cycle helpers.
// The transmitter imports the same package so both ends agree on timing math.
package din_wled_rx_pkg;

  localparam int TCNT_W = 16;

  typedef enum logic [1:0] {
    ST_SYNC = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2
  } state_e;

  function automatic int ns_to_cyc(input int clk_mhz, input int t_ns);
    return (clk_mhz * t_ns) / 1000;
  endfunction

  function automatic int us_to_cyc(input int clk_mhz, input int t_us);
    return clk_mhz * t_us;
  endfunction

endpackage

// File: rtl/din_wled_rx_sync_edge.sv
// Two-flop synchronizer for the asynchronous serial line, plus one history flop
// producing single-cycle rise/fall strobes aligned with the synchronized level.
module wled_sync_edge (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [2:0] sr_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) sr_q <= '0;
    else          sr_q <= {sr_q[1:0], d_i};
  end

  assign level_o = sr_q[1];
  assign rise_o  = sr_q[1] & ~sr_q[2];
  assign fall_o  = ~sr_q[1] & sr_q[2];

endmodule

// File: rtl/din_wled_rx.sv
// WS2812 NRZ receiver: measures high-pulse widths to decode GRB words and
// latches a per-pixel MSB vector for each colour at every reset gap.
module din_wled_rx
  import din_wled_rx_pkg::*;
#(
  parameter int CLK_MHZ     = 27,
  parameter int NUM_LEDS    = 1,
  parameter int THRESH_NS   = 625,
  parameter int MIN_HIGH_NS = 150,
  parameter int MAX_HIGH_NS = 1000,
  parameter int RESET_US    = 50
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                wled_in_i,
  output logic [23:0]         rgb_data_o,
  output logic [7:0]          led_num_o,
  output logic                word_valid_o,
  output logic                frame_done_o,
  output logic [NUM_LEDS-1:0] green_o,
  output logic [NUM_LEDS-1:0] red_o,
  output logic [NUM_LEDS-1:0] blue_o,
  output logic                err_o
);

  localparam logic [TCNT_W-1:0] C_THRESH = TCNT_W'(ns_to_cyc(CLK_MHZ, THRESH_NS));
  localparam logic [TCNT_W-1:0] C_MIN    = TCNT_W'(ns_to_cyc(CLK_MHZ, MIN_HIGH_NS));
  localparam logic [TCNT_W-1:0] C_MAX    = TCNT_W'(ns_to_cyc(CLK_MHZ, MAX_HIGH_NS));
  localparam logic [TCNT_W-1:0] C_RESET  = TCNT_W'(us_to_cyc(CLK_MHZ, RESET_US));

  logic level, rise, fall;

  wled_sync_edge u_sync_edge (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .d_i     (wled_in_i),
    .level_o (level),
    .rise_o  (rise),
    .fall_o  (fall)
  );

  state_e              state_q, state_d;
  logic [TCNT_W-1:0]   tcnt_q;
  logic [4:0]          bit_cnt_q;
  logic [23:0]         shift_q;
  logic                word_rdy_q;
  logic [7:0]          pix_cnt_q;
  logic [NUM_LEDS-1:0] shadow_g_q, shadow_r_q, shadow_b_q;

  logic err_d, frame_d, shift_en, clr_cnt, bit_val;

  // tcnt measures time since the last synced edge: high width in HIGH, low width elsewhere
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)              tcnt_q <= '0;
    else if (rise || fall)     tcnt_q <= '0;
    else if (tcnt_q != '1)     tcnt_q <= tcnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= ST_SYNC;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_SYNC: if (!level && tcnt_q >= C_RESET) state_d = ST_LOW;
      ST_LOW:  if (rise) state_d = ST_HIGH;
      ST_HIGH: begin
        if (tcnt_q > C_MAX)  state_d = ST_SYNC;
        else if (fall)       state_d = (tcnt_q < C_MIN) ? ST_SYNC : ST_LOW;
      end
      default: state_d = ST_SYNC;
    endcase
  end

  always_comb begin
    err_d    = 1'b0;
    frame_d  = 1'b0;
    shift_en = 1'b0;
    clr_cnt  = 1'b0;
    bit_val  = (tcnt_q >= C_THRESH);
    case (state_q)
      ST_LOW: begin
        // equality rather than >= so the latch fires once per gap
        if (!rise && tcnt_q == C_RESET) begin
          frame_d = 1'b1;
          err_d   = (bit_cnt_q != 5'd0);
        end
      end
      ST_HIGH: begin
        if (tcnt_q > C_MAX || (fall && tcnt_q < C_MIN)) begin
          err_d   = 1'b1;
          clr_cnt = 1'b1;
        end else if (fall) begin
          shift_en = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      word_rdy_q   <= 1'b0;
      pix_cnt_q    <= '0;
      shadow_g_q   <= '0;
      shadow_r_q   <= '0;
      shadow_b_q   <= '0;
      rgb_data_o   <= '0;
      led_num_o    <= '0;
      word_valid_o <= 1'b0;
      frame_done_o <= 1'b0;
      green_o      <= '0;
      red_o        <= '0;
      blue_o       <= '0;
      err_o        <= 1'b0;
    end else begin
      err_o        <= err_d;
      frame_done_o <= frame_d;
      word_valid_o <= word_rdy_q;
      word_rdy_q   <= shift_en && (bit_cnt_q == 5'd23);

      if (clr_cnt || frame_d)  bit_cnt_q <= '0;
      else if (shift_en)       bit_cnt_q <= (bit_cnt_q == 5'd23) ? 5'd0 : bit_cnt_q + 5'd1;

      if (shift_en) shift_q <= {shift_q[22:0], bit_val};

      if (word_rdy_q) begin
        rgb_data_o <= shift_q;
        led_num_o  <= pix_cnt_q;
        for (int i = 0; i < NUM_LEDS; i++) begin
          if (pix_cnt_q == 8'(i)) begin
            shadow_g_q[i] <= shift_q[23];
            shadow_r_q[i] <= shift_q[15];
            shadow_b_q[i] <= shift_q[7];
          end
        end
      end

      if (clr_cnt || frame_d)                    pix_cnt_q <= '0;
      else if (word_rdy_q && pix_cnt_q != 8'hFF) pix_cnt_q <= pix_cnt_q + 8'd1;

      if (frame_d) begin
        green_o <= shadow_g_q;
        red_o   <= shadow_r_q;
        blue_o  <= shadow_b_q;
      end
    end
  end

endmodule

// File: tb/tb_din_wled_rx.sv
// Directed bench for din_wled_rx at 27 MHz with two pixels; each task drives one
// scenario and compares against hand-computed values.
module tb_din_wled_rx;

  localparam int T0H  = 11;
  localparam int T1H  = 22;
  localparam int TPER = 34;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wled;
  logic [23:0] rgb;
  logic [7:0]  led;
  logic        wv, fd, err;
  logic [1:0]  green, red, blue;

  din_wled_rx #(.CLK_MHZ(27), .NUM_LEDS(2)) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .wled_in_i    (wled),
    .rgb_data_o   (rgb),
    .led_num_o    (led),
    .word_valid_o (wv),
    .frame_done_o (fd),
    .green_o      (green),
    .red_o        (red),
    .blue_o       (blue),
    .err_o        (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vec = 0;
  int miss = 0;
  int wv_cnt = 0, err_cnt = 0, fd_cnt = 0, both_cnt = 0;
  int last_wv_cyc = 0, last_fall_cyc = 0;
  logic [23:0] wv_rgb [64];
  logic [7:0]  wv_led [64];

  always @(negedge clk) begin
    if (wv) begin
      wv_rgb[wv_cnt % 64] = rgb;
      wv_led[wv_cnt % 64] = led;
      last_wv_cyc = cyc;
      wv_cnt++;
    end
    if (err) err_cnt++;
    if (fd) fd_cnt++;
    if (err && fd) both_cnt++;
  end

  task automatic send_bit(input logic b);
    int h;
    h = b ? T1H : T0H;
    @(negedge clk) wled = 1'b1;
    repeat (h) @(negedge clk);
    wled = 1'b0;
    last_fall_cyc = cyc;
    repeat (TPER - h - 1) @(negedge clk);
  endtask

  // sends the top n bits of w, MSB first
  task automatic send_bits(input logic [23:0] w, input int n);
    for (int i = 23; i > 23 - n; i--) send_bit(w[i]);
  endtask

  task automatic idle(input int n);
    wled = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    wled  = 1'b0;
    repeat (3) @(negedge clk);
    vec++; if (rgb !== 24'h0) begin miss++; $display("FAIL reset_rgb got %h want 000000", rgb); end
    vec++; if (led !== 8'h0) begin miss++; $display("FAIL reset_led got %0d want 0", led); end
    vec++; if ({wv, fd, err} !== 3'b000) begin miss++; $display("FAIL reset_strobes got %b want 000", {wv, fd, err}); end
    vec++; if ({green, red, blue} !== 6'b0) begin miss++; $display("FAIL reset_vectors got %b want 000000", {green, red, blue}); end
  endtask

  task automatic test_lock;
    int b_wv, b_fd, b_err, lf;
    @(negedge clk) rst_n = 1'b1;
    idle(1400);
    b_wv = wv_cnt; b_fd = fd_cnt; b_err = err_cnt;
    send_bits(24'hFF0000, 24);
    send_bits(24'h0000FF, 24);
    lf = last_fall_cyc;
    vec++; if (last_wv_cyc - lf != 4) begin miss++; $display("FAIL lock_latency got %0d want 4", last_wv_cyc - lf); end
    idle(1400);
    vec++; if (wv_cnt - b_wv != 2) begin miss++; $display("FAIL lock_wv_count got %0d want 2", wv_cnt - b_wv); end
    vec++; if (wv_rgb[b_wv % 64] !== 24'hFF0000) begin miss++; $display("FAIL lock_rgb0 got %h want FF0000", wv_rgb[b_wv % 64]); end
    vec++; if (wv_led[b_wv % 64] !== 8'd0) begin miss++; $display("FAIL lock_led0 got %0d want 0", wv_led[b_wv % 64]); end
    vec++; if (wv_rgb[(b_wv + 1) % 64] !== 24'h0000FF) begin miss++; $display("FAIL lock_rgb1 got %h want 0000FF", wv_rgb[(b_wv + 1) % 64]); end
    vec++; if (wv_led[(b_wv + 1) % 64] !== 8'd1) begin miss++; $display("FAIL lock_led1 got %0d want 1", wv_led[(b_wv + 1) % 64]); end
    vec++; if (fd_cnt - b_fd != 1) begin miss++; $display("FAIL lock_fd_count got %0d want 1", fd_cnt - b_fd); end
    vec++; if (err_cnt - b_err != 0) begin miss++; $display("FAIL lock_err_count got %0d want 0", err_cnt - b_err); end
    vec++; if ({green, red, blue} !== {2'b01, 2'b00, 2'b10}) begin miss++; $display("FAIL lock_vectors got g%b r%b b%b want g01 r00 b10", green, red, blue); end
  endtask

  task automatic test_no_lock;
    int b_wv, b_fd, b_err;
    rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    b_wv = wv_cnt; b_fd = fd_cnt; b_err = err_cnt;
    send_bits(24'hFF00FF, 24);
    vec++; if (wv_cnt - b_wv != 0) begin miss++; $display("FAIL nolock_wv got %0d want 0", wv_cnt - b_wv); end
    idle(1400);
    vec++; if (fd_cnt - b_fd != 0) begin miss++; $display("FAIL nolock_fd got %0d want 0", fd_cnt - b_fd); end
    vec++; if (err_cnt - b_err != 0) begin miss++; $display("FAIL nolock_err got %0d want 0", err_cnt - b_err); end
    send_bits(24'h00FF00, 24);
    idle(1400);
    vec++; if (wv_cnt - b_wv != 1) begin miss++; $display("FAIL nolock_wv_after got %0d want 1", wv_cnt - b_wv); end
    vec++; if (wv_rgb[b_wv % 64] !== 24'h00FF00) begin miss++; $display("FAIL nolock_rgb got %h want 00FF00", wv_rgb[b_wv % 64]); end
    vec++; if (fd_cnt - b_fd != 1) begin miss++; $display("FAIL nolock_fd_after got %0d want 1", fd_cnt - b_fd); end
    vec++; if ({green, red, blue} !== {2'b00, 2'b01, 2'b00}) begin miss++; $display("FAIL nolock_vectors got g%b r%b b%b want g00 r01 b00", green, red, blue); end
  endtask

  task automatic test_glitch;
    int b_wv, b_fd, b_err;
    b_wv = wv_cnt; b_fd = fd_cnt; b_err = err_cnt;
    send_bits(24'hAA0000, 8);
    @(negedge clk) wled = 1'b1;
    repeat (3) @(negedge clk);
    wled = 1'b0;
    repeat (30) @(negedge clk);
    vec++; if (err_cnt - b_err != 1) begin miss++; $display("FAIL glitch_err got %0d want 1", err_cnt - b_err); end
    send_bits(24'hFFFF00, 16);
    vec++; if (wv_cnt - b_wv != 0) begin miss++; $display("FAIL glitch_wv got %0d want 0", wv_cnt - b_wv); end
    idle(1400);
    vec++; if (fd_cnt - b_fd != 0) begin miss++; $display("FAIL glitch_fd_gap got %0d want 0", fd_cnt - b_fd); end
    send_bits(24'h0080FF, 24);
    idle(1400);
    vec++; if (wv_cnt - b_wv != 1) begin miss++; $display("FAIL glitch_wv_after got %0d want 1", wv_cnt - b_wv); end
    vec++; if (wv_rgb[b_wv % 64] !== 24'h0080FF) begin miss++; $display("FAIL glitch_rgb got %h want 0080FF", wv_rgb[b_wv % 64]); end
    vec++; if (err_cnt - b_err != 1) begin miss++; $display("FAIL glitch_err_total got %0d want 1", err_cnt - b_err); end
    vec++; if ({green, red, blue} !== {2'b00, 2'b01, 2'b01}) begin miss++; $display("FAIL glitch_vectors got g%b r%b b%b want g00 r01 b01", green, red, blue); end
  endtask

  task automatic test_partial;
    int b_wv, b_fd, b_err, b_both;
    b_wv = wv_cnt; b_fd = fd_cnt; b_err = err_cnt; b_both = both_cnt;
    send_bits(24'hFFF000, 12);
    idle(1400);
    vec++; if (err_cnt - b_err != 1) begin miss++; $display("FAIL partial_err got %0d want 1", err_cnt - b_err); end
    vec++; if (fd_cnt - b_fd != 1) begin miss++; $display("FAIL partial_fd got %0d want 1", fd_cnt - b_fd); end
    vec++; if (both_cnt - b_both != 1) begin miss++; $display("FAIL partial_same_cycle got %0d want 1", both_cnt - b_both); end
    vec++; if (wv_cnt - b_wv != 0) begin miss++; $display("FAIL partial_wv got %0d want 0", wv_cnt - b_wv); end
    vec++; if ({green, red, blue} !== {2'b00, 2'b01, 2'b01}) begin miss++; $display("FAIL partial_vectors got g%b r%b b%b want g00 r01 b01", green, red, blue); end
  endtask

  task automatic test_overflow;
    int b_wv, b_fd;
    b_wv = wv_cnt; b_fd = fd_cnt;
    send_bits(24'hFF0000, 24);
    send_bits(24'h00FF00, 24);
    send_bits(24'h0000FF, 24);
    idle(1400);
    vec++; if (wv_cnt - b_wv != 3) begin miss++; $display("FAIL ovf_wv got %0d want 3", wv_cnt - b_wv); end
    vec++; if (wv_led[b_wv % 64] !== 8'd0) begin miss++; $display("FAIL ovf_led0 got %0d want 0", wv_led[b_wv % 64]); end
    vec++; if (wv_led[(b_wv + 1) % 64] !== 8'd1) begin miss++; $display("FAIL ovf_led1 got %0d want 1", wv_led[(b_wv + 1) % 64]); end
    vec++; if (wv_led[(b_wv + 2) % 64] !== 8'd2) begin miss++; $display("FAIL ovf_led2 got %0d want 2", wv_led[(b_wv + 2) % 64]); end
    vec++; if (wv_rgb[(b_wv + 2) % 64] !== 24'h0000FF) begin miss++; $display("FAIL ovf_rgb2 got %h want 0000FF", wv_rgb[(b_wv + 2) % 64]); end
    vec++; if (fd_cnt - b_fd != 1) begin miss++; $display("FAIL ovf_fd got %0d want 1", fd_cnt - b_fd); end
    vec++; if ({green, red, blue} !== {2'b01, 2'b10, 2'b00}) begin miss++; $display("FAIL ovf_vectors got g%b r%b b%b want g01 r10 b00", green, red, blue); end
  endtask

  task automatic test_async_reset;
    int b_wv, b_fd;
    send_bits(24'hFFFFFF, 9);
    @(negedge clk) wled = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    vec++; if ({green, red, blue} !== 6'b0) begin miss++; $display("FAIL arst_vectors got %b want 000000", {green, red, blue}); end
    vec++; if (rgb !== 24'h0) begin miss++; $display("FAIL arst_rgb got %h want 000000", rgb); end
    vec++; if (led !== 8'h0) begin miss++; $display("FAIL arst_led got %0d want 0", led); end
    vec++; if ({wv, fd, err} !== 3'b000) begin miss++; $display("FAIL arst_strobes got %b want 000", {wv, fd, err}); end
    wled = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    b_wv = wv_cnt; b_fd = fd_cnt;
    send_bits(24'hFFFFFF, 24);
    vec++; if (wv_cnt - b_wv != 0) begin miss++; $display("FAIL arst_nolock_wv got %0d want 0", wv_cnt - b_wv); end
    idle(1400);
    vec++; if (fd_cnt - b_fd != 0) begin miss++; $display("FAIL arst_gap_fd got %0d want 0", fd_cnt - b_fd); end
    send_bits(24'h808080, 24);
    idle(1400);
    vec++; if (wv_cnt - b_wv != 1) begin miss++; $display("FAIL arst_wv_after got %0d want 1", wv_cnt - b_wv); end
    vec++; if (wv_rgb[b_wv % 64] !== 24'h808080) begin miss++; $display("FAIL arst_rgb_after got %h want 808080", wv_rgb[b_wv % 64]); end
    vec++; if (wv_led[b_wv % 64] !== 8'd0) begin miss++; $display("FAIL arst_led_after got %0d want 0", wv_led[b_wv % 64]); end
    vec++; if (fd_cnt - b_fd != 1) begin miss++; $display("FAIL arst_fd_after got %0d want 1", fd_cnt - b_fd); end
    vec++; if ({green, red, blue} !== {2'b01, 2'b01, 2'b01}) begin miss++; $display("FAIL arst_vectors_after got g%b r%b b%b want g01 r01 b01", green, red, blue); end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_no_lock();
    test_glitch();
    test_partial();
    test_overflow();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
